// File: rtl/cpu_press_pkg.sv
// Shared types for the computer-player button presser: FSM state encoding and
// the width of the pulse and cool counters.
package cpu_press_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        PRESS,
        COOL
    } state_t;

endpackage

// File: rtl/cpu_press_tick_gen.sv
// Clearable divide-by-TICK_DIV counter; tick marks the last count of each period
// and the counter wraps to zero on that same cycle.
module tick_gen
    import cpu_press_pkg::*;
#(
    parameter int TICK_DIV = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign tick = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_press.sv
// Computer-player button presser: on each sample tick, presses when the random
// value is below the difficulty threshold, then blocks for a cool-down period.
module cpu_press
    import cpu_press_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int TICK_DIV = 16,
    parameter int COOL_CYC = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] rnd,
    input  logic [WIDTH-1:0] thresh,
    input  logic             enable,
    output logic             press,
    output logic [CNT_W-1:0] press_cnt,
    output logic             cooling
);

    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOL_CYC - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cool_q;
    logic [CNT_W-1:0] cool_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;
    logic             cooling_q;
    logic             cooling_d;
    logic             tick;
    logic             tick_clr;
    logic             tick_run;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Divider only advances in SAMPLE; any other state or a dropped enable
    // discards partial progress so each sampling run starts from zero.
    assign tick_run = (state_q == SAMPLE);
    assign tick_clr = (state_q != SAMPLE) || !enable;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (tick_clr),
        .run    (tick_run),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        cool_d  = cool_q;
        case (state_q)
            IDLE: begin
                cool_d = '0;
                if (enable) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (tick && (rnd < thresh)) begin
                    state_d = PRESS;
                end
            end
            PRESS: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    state_d = COOL;
                    cool_d  = COOL_LOAD;
                end
            end
            COOL: begin
                if (!enable) begin
                    state_d = IDLE;
                    cool_d  = '0;
                end else if (cool_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cool_d = cool_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cool_d  = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change with the state.
    always_comb begin
        press_d   = (state_d == PRESS);
        cooling_d = (state_d == COOL);
        cnt_d     = press_d ? sat_inc(cnt_q) : cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cool_q    <= '0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            cooling_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cool_q    <= cool_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            cooling_q <= cooling_d;
        end
    end

    assign press     = press_q;
    assign cooling   = cooling_q;
    assign press_cnt = cnt_q;

endmodule
